// File: rtl/bounce_generator.sv
// Contact-bounce emulator: turns each accepted level change on signal_in into a burst of
// alternating segments before settling. Define BOUNCE_LFSR_EN for pseudo-random segment widths.
module bounce_generator #(
  parameter int unsigned BOUNCE_PAIRS = 3,
  parameter int unsigned BASE_WIDTH   = 2,
  parameter int unsigned WIDTH_STEP   = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic signal_out,
  output logic busy,
  output logic done
);

  typedef enum logic {IDLE, BOUNCE} state_e;

  localparam int unsigned      LAST_SEG = (BOUNCE_PAIRS == 0) ? 0 : 2 * BOUNCE_PAIRS - 1;
  localparam logic [CNT_W-1:0] SEG_LAST = CNT_W'(LAST_SEG);
  localparam logic [CNT_W-1:0] BASE_M1  = CNT_W'(BASE_WIDTH - 1);

  state_e           state_q;
  logic             target_q;
  logic             out_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] seg_q;
  logic [CNT_W-1:0] cnt_q;
  // Counter reload values (segment width minus one) for the first and the following segment.
  logic [CNT_W-1:0] first_w_d;
  logic [CNT_W-1:0] next_w_d;

`ifdef BOUNCE_LFSR_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        seg_start_d;

  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    first_w_d   = BASE_M1 + CNT_W'(lfsr_q[3:0]);
    next_w_d    = first_w_d;
    seg_start_d = ((state_q == IDLE) && (signal_in != out_q) && (BOUNCE_PAIRS != 0)) ||
                  ((state_q == BOUNCE) && (cnt_q == '0) && (seg_q != SEG_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (seg_start_d) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic [CNT_W-1:0] width_q;

  always_comb begin
    first_w_d = BASE_M1;
    next_w_d  = width_q + CNT_W'(WIDTH_STEP);
  end

  // Tracks the reload value of the running segment so the ramp needs only an adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q <= '0;
    end else if (state_q == IDLE) begin
      width_q <= BASE_M1;
    end else if (cnt_q == '0) begin
      width_q <= next_w_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (signal_in != out_q) begin
            out_q <= signal_in;
            if (BOUNCE_PAIRS == 0) begin
              done_q <= 1'b1;
            end else begin
              target_q <= signal_in;
              seg_q    <= '0;
              cnt_q    <= first_w_d;
              busy_q   <= 1'b1;
              state_q  <= BOUNCE;
            end
          end
        end
        BOUNCE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (seg_q == SEG_LAST) begin
            out_q   <= target_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            // Even segments carry the target level, odd ones its complement.
            seg_q <= seg_q + 1'b1;
            cnt_q <= next_w_d;
            out_q <= target_q ^ ~seg_q[0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign signal_out = out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Scoreboard bench for bounce_generator: a default-parameter instance and an N=0 passthrough instance.
module tb_bounce_generator;

  localparam int N = 3;
  localparam int B = 2;
  localparam int S = 1;
  localparam int L = 2 * N * B + S * N * (2 * N - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signal_in = 1'b0;
  logic signal_out, busy, done;
  logic out0, busy0, done0;

  bounce_generator #(.BOUNCE_PAIRS(N), .BASE_WIDTH(B), .WIDTH_STEP(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .signal_out(signal_out), .busy(busy), .done(done)
  );

  bounce_generator #(.BOUNCE_PAIRS(0), .BASE_WIDTH(B), .WIDTH_STEP(S), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .signal_out(out0), .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(negedge clk) ncyc++;

  typedef struct { int t_acc; bit target; } burst_t;
  typedef struct { bit out; bit dn; } pass_t;
  burst_t sbq[$];
  pass_t  q0[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
  endtask

  // Reference model: a burst occupies L cycles after acceptance, input is ignored meanwhile.
  bit mo  = 1'b0;
  int brem = 0;
  bit mo0 = 1'b0;

  task automatic model_edge();
    if (rst) begin
      mo = 1'b0; brem = 0; sbq.delete();
    end else if (brem > 0) begin
      brem--;
    end else if (signal_in != mo) begin
      sbq.push_back('{t_acc: ncyc, target: signal_in});
      mo = signal_in;
      brem = L;
    end
    if (rst) begin
      q0.push_back('{out: 1'b0, dn: 1'b0});
      mo0 = 1'b0;
    end else begin
      q0.push_back('{out: signal_in, dn: (signal_in != mo0)});
      mo0 = signal_in;
    end
  endtask

  task automatic drive(input bit r, input bit s, input int n);
    repeat (n) begin
      rst = r;
      signal_in = s;
      @(posedge clk);
      model_edge();
      #2;
    end
  endtask

  // Monitor state: run lengths of signal_out observed while busy.
  int run_len[$];
  bit run_lvl[$];
  int cur_len = 0;
  bit cur_lvl = 1'b0;
  int busy_cnt = 0;
  int start_cyc = 0;
  bit active = 1'b0;
  bit prev_done = 1'b0;

  task automatic mon_main();
    burst_t e;
    if (rst) begin
      chk(signal_out == 1'b0, "rst_out", signal_out, 0);
      chk(busy == 1'b0, "rst_busy", busy, 0);
      chk(done == 1'b0, "rst_done", done, 0);
      run_len.delete(); run_lvl.delete();
      active = 1'b0; busy_cnt = 0; prev_done = 1'b0;
      return;
    end
    if (busy) begin
      if (!active) begin
        active = 1'b1; start_cyc = ncyc; busy_cnt = 1;
        run_len.delete(); run_lvl.delete();
        cur_lvl = signal_out; cur_len = 1;
      end else begin
        busy_cnt++;
        if (signal_out == cur_lvl) cur_len++;
        else begin
          run_len.push_back(cur_len); run_lvl.push_back(cur_lvl);
          cur_lvl = signal_out; cur_len = 1;
        end
      end
    end
    if (done) begin
      if (active) begin
        run_len.push_back(cur_len); run_lvl.push_back(cur_lvl);
      end
      chk(busy == 1'b0, "done_busy", busy, 0);
      chk(prev_done == 1'b0, "done_once", prev_done, 0);
      if (sbq.size() == 0) begin
        chk(1'b0, "sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk(start_cyc == e.t_acc, "latency", start_cyc, e.t_acc);
        chk(busy_cnt == L, "busy_len", busy_cnt, L);
        chk(signal_out == e.target, "final_level", signal_out, e.target);
        chk(run_len.size() == 2 * N, "seg_count", run_len.size(), 2 * N);
        for (int i = 0; i < run_len.size() && i < 2 * N; i++) begin
          chk(run_len[i] == B + i * S, "seg_width", run_len[i], B + i * S);
          chk(run_lvl[i] == (e.target ^ (i % 2 == 1)), "seg_level", run_lvl[i],
              e.target ^ (i % 2 == 1));
        end
      end
      active = 1'b0;
      run_len.delete(); run_lvl.delete();
    end
    prev_done = done;
  endtask

  task automatic mon_pass();
    pass_t p;
    if (q0.size() == 0) begin
      chk(1'b0, "q0_underflow", 1, 0);
      return;
    end
    p = q0.pop_front();
    chk(out0 == p.out, "pass_out", out0, p.out);
    chk(done0 == p.dn, "pass_done", done0, p.dn);
    chk(busy0 == 1'b0, "pass_busy", busy0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_main();
      mon_pass();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit drained;
    drive(1, 1, 3);                 // reset held with signal_in high
    drive(0, 1, 35);                // rising burst after release
    drive(0, 0, 40);                // falling burst
    drive(0, 1, 40);                // rising burst
    drive(0, 0, 40);
    drive(0, 1, 4);                 // chatter during a rising burst
    drive(0, 0, 4);
    drive(0, 1, 4);
    drive(0, 0, 70);
    drive(0, 1, 1);                 // single-cycle pulse
    drive(0, 0, 40);
    drive(0, 1, 11);                // reset inside segment 3
    drive(1, 1, 1);
    drive(0, 1, 40);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 15) == 0)
        drive(1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      else
        drive(0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 35)));
    end
    drained = 1'b0;
    for (int k = 0; k < 200; k++) begin
      drive(0, signal_in, 1);
      if (brem == 0 && !busy && !done && sbq.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    chk(drained, "drain", drained, 1);
    chk(signal_out == mo, "final_out", signal_out, mo);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
